// File: rtl/led_fb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : led_fb_arbiter
// Purpose  : Write-side controller for the double-buffered 8x8 RGB frame
//            store. Round-robin shares one pixel-RAM write port between the
//            SPI receiver (A) and the pattern engine (B), and swaps the
//            front/back banks only at scan frame boundaries.
// Options  : LED_FB_STATS_EN adds wr_count / drop_count statistics outputs.
// Revision : 1.0  initial release
// ============================================================================
module led_fb_arbiter #(
    parameter int NUM_PIX = 64,
    parameter int ADDR_W  = 6,
    parameter int PIX_W   = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [PIX_W-1:0]  a_rgb,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [PIX_W-1:0]  b_rgb,
    input  logic              swap_req,
    input  logic              frame_end,
    output logic              swap_pending,
    output logic              swap_done,
    output logic              front_sel,
    output logic              wr_en,
    output logic              wr_bank,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [PIX_W-1:0]  wr_rgb
`ifdef LED_FB_STATS_EN
    ,
    output logic [15:0]       wr_count,
    output logic [7:0]        drop_count
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_SWAP    = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_prio_b;       // 0: A holds priority, 1: B holds priority
    logic              r_swap_pending;
    logic              r_swap_done;
    logic              r_front_sel;
    logic              r_wr_en;
    logic              r_wr_bank;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [PIX_W-1:0]  r_wr_rgb;

    logic              w_idle;
    logic              w_a_xfer;
    logic              w_b_xfer;
    logic              w_xfer;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [PIX_W-1:0]  w_sel_rgb;
    logic              w_in_range;
    logic              w_swap_go;

    // Grants only in IDLE and never while reset is held; ties go to the priority holder.
    assign w_idle     = (r_state == ST_IDLE) && !rst;
    assign a_ready    = w_idle && a_valid && (!b_valid || !r_prio_b);
    assign b_ready    = w_idle && b_valid && (!a_valid ||  r_prio_b);
    assign w_a_xfer   = a_valid && a_ready;
    assign w_b_xfer   = b_valid && b_ready;
    assign w_xfer     = w_a_xfer || w_b_xfer;
    assign w_sel_addr = w_a_xfer ? a_addr : b_addr;
    assign w_sel_rgb  = w_a_xfer ? a_rgb  : b_rgb;
    assign w_in_range = 32'(w_sel_addr) < NUM_PIX;
    assign w_swap_go  = (r_state == ST_PENDING) && frame_end;

    assign swap_pending = r_swap_pending;
    assign swap_done    = r_swap_done;
    assign front_sel    = r_front_sel;
    assign wr_en        = r_wr_en;
    assign wr_bank      = r_wr_bank;
    assign wr_addr      = r_wr_addr;
    assign wr_rgb       = r_wr_rgb;

    // Round-robin pointer: any grant hands priority to the other requester.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prio_b <= 1'b0;
        end else if (w_a_xfer) begin
            r_prio_b <= 1'b1;
        end else if (w_b_xfer) begin
            r_prio_b <= 1'b0;
        end
    end

    // Swap FSM: freeze writers once a swap is requested, flip banks on frame_end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_swap_pending <= 1'b0;
            r_swap_done    <= 1'b0;
            r_front_sel    <= 1'b0;
        end else begin
            r_swap_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // frame_end is deliberately ignored here, even alongside swap_req.
                    if (swap_req) begin
                        r_state        <= ST_PENDING;
                        r_swap_pending <= 1'b1;
                    end
                end
                ST_PENDING: begin
                    if (frame_end) begin
                        r_state        <= ST_SWAP;
                        r_swap_pending <= 1'b0;
                        r_swap_done    <= 1'b1;
                        r_front_sel    <= ~r_front_sel;
                    end
                end
                ST_SWAP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Write stage: bank is latched at accept time so a write retiring during
    // PENDING still targets the bank that was back when it was accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_en   <= 1'b0;
            r_wr_bank <= 1'b0;
            r_wr_addr <= '0;
            r_wr_rgb  <= '0;
        end else begin
            r_wr_en <= w_xfer && w_in_range;
            if (w_xfer) begin
                r_wr_bank <= ~r_front_sel;
                r_wr_addr <= w_sel_addr;
                r_wr_rgb  <= w_sel_rgb;
            end
        end
    end

`ifdef LED_FB_STATS_EN
    logic [15:0] r_wr_count;
    logic [7:0]  r_drop_count;

    assign wr_count   = r_wr_count;
    assign drop_count = r_drop_count;

    // Saturating statistics; the write count restarts with each new front frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_count   <= '0;
            r_drop_count <= '0;
        end else begin
            if (w_swap_go) begin
                r_wr_count <= '0;
            end else if (r_wr_en && (r_wr_count != 16'hFFFF)) begin
                r_wr_count <= r_wr_count + 16'd1;
            end
            if (w_xfer && !w_in_range && (r_drop_count != 8'hFF)) begin
                r_drop_count <= r_drop_count + 8'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_led_fb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_fb_arbiter
// Purpose  : Directed self-checking bench for led_fb_arbiter (ADDR_W=7 so
//            out-of-range addresses can be driven).
// Revision : 1.0  initial release
// ============================================================================
module tb_led_fb_arbiter;

    localparam int c_NUM_PIX = 64;
    localparam int c_ADDR_W  = 7;
    localparam int c_PIX_W   = 24;

    logic                clk;
    logic                rst;
    logic                a_valid;
    logic                a_ready;
    logic [c_ADDR_W-1:0] a_addr;
    logic [c_PIX_W-1:0]  a_rgb;
    logic                b_valid;
    logic                b_ready;
    logic [c_ADDR_W-1:0] b_addr;
    logic [c_PIX_W-1:0]  b_rgb;
    logic                swap_req;
    logic                frame_end;
    logic                swap_pending;
    logic                swap_done;
    logic                front_sel;
    logic                wr_en;
    logic                wr_bank;
    logic [c_ADDR_W-1:0] wr_addr;
    logic [c_PIX_W-1:0]  wr_rgb;
`ifdef LED_FB_STATS_EN
    logic [15:0]         wr_count;
    logic [7:0]          drop_count;
`endif

    int n_vec;
    int n_err;

    led_fb_arbiter #(
        .NUM_PIX (c_NUM_PIX),
        .ADDR_W  (c_ADDR_W),
        .PIX_W   (c_PIX_W)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .a_valid      (a_valid),
        .a_ready      (a_ready),
        .a_addr       (a_addr),
        .a_rgb        (a_rgb),
        .b_valid      (b_valid),
        .b_ready      (b_ready),
        .b_addr       (b_addr),
        .b_rgb        (b_rgb),
        .swap_req     (swap_req),
        .frame_end    (frame_end),
        .swap_pending (swap_pending),
        .swap_done    (swap_done),
        .front_sel    (front_sel),
        .wr_en        (wr_en),
        .wr_bank      (wr_bank),
        .wr_addr      (wr_addr),
        .wr_rgb       (wr_rgb)
`ifdef LED_FB_STATS_EN
        ,
        .wr_count     (wr_count),
        .drop_count   (drop_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        rst = 1'b1;
        a_valid = 1'b0; a_addr = '0; a_rgb = '0;
        b_valid = 1'b0; b_addr = '0; b_rgb = '0;
        swap_req = 1'b0; frame_end = 1'b0;
        tick(); tick();

        // Reset state; ready must stay low while rst is high.
        a_valid = 1'b1; a_addr = 7'd3; #1;
        chk("rst_a_ready",    a_ready,      0);
        chk("rst_front_sel",  front_sel,    0);
        chk("rst_pending",    swap_pending, 0);
        chk("rst_swap_done",  swap_done,    0);
        chk("rst_wr_en",      wr_en,        0);
        chk("rst_wr_bank",    wr_bank,      0);
        chk("rst_wr_addr",    wr_addr,      0);
        chk("rst_wr_rgb",     wr_rgb,       0);
        a_valid = 1'b0; rst = 1'b0;

        // Single requester A, one-cycle write latency into back bank 1.
        a_valid = 1'b1; a_addr = 7'd5; a_rgb = 24'hFF8000; #1;
        chk("t1_a_ready", a_ready, 1);
        chk("t1_b_ready", b_ready, 0);
        tick(); a_valid = 1'b0;
        chk("t1_wr_en",   wr_en,   1);
        chk("t1_wr_addr", wr_addr, 5);
        chk("t1_wr_rgb",  wr_rgb,  24'hFF8000);
        chk("t1_wr_bank", wr_bank, 1);
        tick();
        chk("t1_wr_idle", wr_en, 0);

        // Fresh reset, then both requesters held: A,B,A,B.
        rst = 1'b1; #1; rst = 1'b0;
        a_valid = 1'b1; a_addr = 7'd1; a_rgb = 24'h0000AA;
        b_valid = 1'b1; b_addr = 7'd2; b_rgb = 24'h00BB00;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_a_ready", a_ready, (i % 2) == 0);
            chk("rr_b_ready", b_ready, (i % 2) == 1);
            tick();
            chk("rr_wr_en",   wr_en, 1);
            chk("rr_wr_addr", wr_addr, ((i % 2) == 0) ? 1 : 2);
        end
        a_valid = 1'b0; b_valid = 1'b0;
        tick();
        chk("rr_wr_idle", wr_en, 0);

        // Swap request, frame_end ten cycles later; writers frozen throughout.
        swap_req = 1'b1; #1;
        tick(); swap_req = 1'b0;
        chk("t3_pending", swap_pending, 1);
        a_valid = 1'b1; b_valid = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            frame_end = (k == 10); #1;
            chk("t3_pend_rdy", {a_ready, b_ready}, 0);
            tick();
        end
        frame_end = 1'b0;
        chk("t3_swap_done", swap_done,    1);
        chk("t3_front_sel", front_sel,    1);
        chk("t3_pending_0", swap_pending, 0);
        chk("t3_swap_rdy",  {a_ready, b_ready}, 0);
        tick();
        chk("t3_done_pulse", swap_done, 0);
        chk("t3_idle_rdy",   {a_ready, b_ready}, 2'b10);
        a_valid = 1'b0; b_valid = 1'b0;

        // Transfer coincident with swap_req lands in old back bank (0), then reset mid-PENDING.
        a_valid = 1'b1; a_addr = 7'd10; a_rgb = 24'h123456; swap_req = 1'b1; #1;
        chk("t6_a_ready", a_ready, 1);
        tick(); a_valid = 1'b0; swap_req = 1'b0;
        chk("t6_wr_en",   wr_en,        1);
        chk("t6_wr_bank", wr_bank,      0);
        chk("t6_pending", swap_pending, 1);
        rst = 1'b1; #1;
        chk("t6_rst_pending", swap_pending, 0);
        chk("t6_rst_wr_en",   wr_en,        0);
        chk("t6_rst_front",   front_sel,    0);
        rst = 1'b0;
        a_valid = 1'b1; b_valid = 1'b1; #1;
        chk("t6_first_grant", {a_ready, b_ready}, 2'b10);
        tick(); a_valid = 1'b0; b_valid = 1'b0;
        chk("t6_wr_addr", wr_addr, 10);
        chk("t6_wr_bank2", wr_bank, 1);

        // swap_req with frame_end in the same cycle only arms the swap.
        swap_req = 1'b1; frame_end = 1'b1; #1;
        tick(); swap_req = 1'b0; frame_end = 1'b0;
        chk("t4_pending",   swap_pending, 1);
        chk("t4_front_sel", front_sel,    0);
        chk("t4_no_done",   swap_done,    0);
        tick(); tick();
        chk("t4_still_pend", swap_pending, 1);
        chk("t4_still_front", front_sel,   0);
        frame_end = 1'b1; #1;
        tick(); frame_end = 1'b0;
        chk("t4_swap_done", swap_done, 1);
        chk("t4_front_sel1", front_sel, 1);
`ifdef LED_FB_STATS_EN
        chk("t4_wr_count_clr", wr_count, 0);
`endif
        tick();
        chk("t4_done_pulse", swap_done, 0);

        // Out-of-range B write handshakes but never strobes the RAM.
        b_valid = 1'b1; b_addr = 7'd64; b_rgb = 24'h00FF00; #1;
        chk("t5_b_ready", b_ready, 1);
        tick(); b_valid = 1'b0;
        chk("t5_wr_en_drop", wr_en, 0);
`ifdef LED_FB_STATS_EN
        chk("t5_drop_count", drop_count, 1);
`endif
        b_valid = 1'b1; b_addr = 7'd63; b_rgb = 24'h0000FF; #1;
        chk("t5_b_ready2", b_ready, 1);
        tick(); b_valid = 1'b0;
        chk("t5_wr_en",   wr_en,   1);
        chk("t5_wr_addr", wr_addr, 63);
        chk("t5_wr_bank", wr_bank, 0);
        tick();
        chk("t5_wr_idle", wr_en, 0);
`ifdef LED_FB_STATS_EN
        chk("t5_wr_count", wr_count, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
